pin_driver: RTL and testbench

- Output-side companion to the GPIO input filter: drives one tri-statable pin toward the cartridge/host bus.
- Enforces a minimum hold time per driven level, a pre-release drive-high (precharge), and a turnaround gap before re-driving.
- Paced by the same `ena` tick as the input filter.
- Reports driven edges as one-clock strobes, so logic that reads the pin back can be matched against the filter's edge outputs.

---
 rtl/pin_driver_pkg.sv | 20 ++
 rtl/pin_driver_tick.sv | 32 +++
 rtl/pin_driver.sv | 156 +++++++++++++++
 tb/tb_pin_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pin_driver_pkg.sv
// Shared types and helpers for the GPIO pin driver and input filter.
// Holds the driver state encoding and the tick-counter width rule.
package pin_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        PRECHG = 2'd2
    } pin_state_t;

    // Width of a down-counter able to hold the largest of three tick counts.
    function automatic int tick_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pin_driver_tick.sv
// Loadable down-counter paced by the ena tick.
// Saturates at zero and reports a zero flag.
module tick_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_ena,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load has priority over decrement; both only act on ena ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_ena) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pin_driver.sv
// Tri-state pin driver with minimum hold, precharge and turnaround.
// Emits one-clock strobes for every driven edge of the pin.
module pin_driver
    import pin_driver_pkg::*;
#(
    parameter int MIN_HOLD   = 2,
    parameter int PRECHARGE  = 1,
    parameter int TURNAROUND = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ena,
    input  logic oe_req,
    input  logic din,
    output logic pin_o,
    output logic pin_oe,
    output logic busy,
    output logic pos_edge,
    output logic neg_edge
);

    localparam int CW = tick_cnt_w(MIN_HOLD, PRECHARGE, TURNAROUND);
    localparam logic [CW-1:0] HOLD_LD = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] PRE_LD  = CW'((PRECHARGE > 0) ? PRECHARGE - 1 : 0);
    localparam logic [CW-1:0] TA_LD   = CW'(TURNAROUND);
    localparam logic          HAS_PRE = (PRECHARGE > 0);

    pin_state_t r_state;
    pin_state_t w_state_nx;

    logic r_pin_o, r_pin_oe, r_pos, r_neg;
    logic w_pin_o_nx, w_pin_oe_nx, w_pos_nx, w_neg_nx;

    logic w_hold_zero, w_pre_zero, w_ta_zero;

    logic w_idle, w_drive, w_prechg_st;
    logic w_start, w_ta_tick;
    logic w_hold_tick, w_rel, w_prechg, w_off_drive, w_chg;
    logic w_pre_tick, w_off_pre;

    assign w_idle      = (r_state == IDLE);
    assign w_drive     = (r_state == DRIVE);
    assign w_prechg_st = (r_state == PRECHG);

    assign w_start     = ena & w_idle & w_ta_zero & oe_req;
    assign w_ta_tick   = ena & w_idle & ~w_ta_zero;
    assign w_hold_tick = ena & w_drive & ~w_hold_zero;
    assign w_rel       = ena & w_drive & w_hold_zero & ~oe_req;
    assign w_prechg    = w_rel & ~r_pin_o & HAS_PRE;
    assign w_off_drive = w_rel & ~w_prechg;
    assign w_chg       = ena & w_drive & w_hold_zero & oe_req
                       & (din != r_pin_o);
    assign w_pre_tick  = ena & w_prechg_st & ~w_pre_zero;
    assign w_off_pre   = ena & w_prechg_st & w_pre_zero;

    tick_counter #(.W(CW)) u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ena      (ena),
        .i_load     (w_start | w_chg),
        .i_load_val (HOLD_LD),
        .i_dec      (w_hold_tick),
        .o_zero     (w_hold_zero)
    );

    tick_counter #(.W(CW)) u_pre (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ena      (ena),
        .i_load     (w_prechg),
        .i_load_val (PRE_LD),
        .i_dec      (w_pre_tick),
        .o_zero     (w_pre_zero)
    );

    tick_counter #(.W(CW)) u_ta (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_ena      (ena),
        .i_load     (w_off_drive | w_off_pre),
        .i_load_val (TA_LD),
        .i_dec      (w_ta_tick),
        .o_zero     (w_ta_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    // Next-state selection from the mutually exclusive tick events.
    always_comb begin
        w_state_nx = r_state;
        unique case (1'b1)
            w_start:                w_state_nx = DRIVE;
            w_prechg:               w_state_nx = PRECHG;
            w_off_drive, w_off_pre: w_state_nx = IDLE;
            default:                w_state_nx = r_state;
        endcase
    end

    // Next pin level, enable and edge strobes; a release beats a level change.
    always_comb begin
        w_pin_o_nx  = r_pin_o;
        w_pin_oe_nx = r_pin_oe;
        w_pos_nx    = 1'b0;
        w_neg_nx    = 1'b0;
        unique case (1'b1)
            w_start: begin
                w_pin_oe_nx = 1'b1;
                w_pin_o_nx  = din;
                w_pos_nx    = din & ~r_pin_o;
                w_neg_nx    = ~din & r_pin_o;
            end
            w_chg: begin
                w_pin_o_nx = din;
                w_pos_nx   = din;
                w_neg_nx   = ~din;
            end
            w_prechg: begin
                w_pin_o_nx = 1'b1;
                w_pos_nx   = 1'b1;
            end
            w_off_drive, w_off_pre: begin
                w_pin_oe_nx = 1'b0;
            end
            default: begin
                w_pin_o_nx  = r_pin_o;
                w_pin_oe_nx = r_pin_oe;
            end
        endcase
    end

    // Output registers; strobes self-clear on the following clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pin_o  <= 1'b1;
            r_pin_oe <= 1'b0;
            r_pos    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_pin_o  <= w_pin_o_nx;
            r_pin_oe <= w_pin_oe_nx;
            r_pos    <= w_pos_nx;
            r_neg    <= w_neg_nx;
        end
    end

    assign pin_o    = r_pin_o;
    assign pin_oe   = r_pin_oe;
    assign pos_edge = r_pos;
    assign neg_edge = r_neg;
    assign busy     = ~w_idle | ~w_ta_zero;

endmodule

// File: tb/tb_pin_driver.sv
// Scoreboard bench for pin_driver: default instance plus a
// no-precharge, no-turnaround instance driven with the same stimulus.
module tb_pin_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ena = 1'b0;
    logic oe_req = 1'b0;
    logic din = 1'b0;

    logic po0, oe0, bz0, pe0, ne0;
    logic po1, oe1, bz1, pe1, ne1;

    int n_chk = 0;
    int n_err = 0;
    string g_tag = "init";

    always #5 clk = ~clk;

    pin_driver u0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena      (ena),
        .oe_req   (oe_req),
        .din      (din),
        .pin_o    (po0),
        .pin_oe   (oe0),
        .busy     (bz0),
        .pos_edge (pe0),
        .neg_edge (ne0)
    );

    pin_driver #(.MIN_HOLD(2), .PRECHARGE(0), .TURNAROUND(0)) u1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena      (ena),
        .oe_req   (oe_req),
        .din      (din),
        .pin_o    (po1),
        .pin_oe   (oe1),
        .busy     (bz1),
        .pos_edge (pe1),
        .neg_edge (ne1)
    );

    // Reference model state, index 0 = u0, 1 = u1.
    int m_mh[2] = '{2, 2};
    int m_pc[2] = '{1, 0};
    int m_ta[2] = '{1, 0};
    int m_st[2];
    int m_hold[2];
    int m_pre[2];
    int m_tac[2];
    bit m_po[2];
    bit m_oe[2];
    bit m_pe[2];
    bit m_ne[2];

    logic [4:0] q0[$];
    logic [4:0] q1[$];

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_hold[k] = 0; m_pre[k] = 0; m_tac[k] = 0;
            m_po[k] = 1'b1; m_oe[k] = 1'b0; m_pe[k] = 1'b0; m_ne[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input bit r,
                              input bit d);
        bit p, n;
        p = 1'b0;
        n = 1'b0;
        if (e) begin
            if (m_st[k] == 0) begin
                if (m_tac[k] > 0) begin
                    m_tac[k]--;
                end else if (r) begin
                    p = d && !m_po[k];
                    n = !d && m_po[k];
                    m_po[k] = d;
                    m_oe[k] = 1'b1;
                    m_hold[k] = m_mh[k] - 1;
                    m_st[k] = 1;
                end
            end else if (m_st[k] == 1) begin
                if (m_hold[k] > 0) begin
                    m_hold[k]--;
                end else if (!r) begin
                    if (!m_po[k] && m_pc[k] > 0) begin
                        m_po[k] = 1'b1;
                        p = 1'b1;
                        m_pre[k] = m_pc[k] - 1;
                        m_st[k] = 2;
                    end else begin
                        m_oe[k] = 1'b0;
                        m_tac[k] = m_ta[k];
                        m_st[k] = 0;
                    end
                end else if (d != m_po[k]) begin
                    p = d;
                    n = !d;
                    m_po[k] = d;
                    m_hold[k] = m_mh[k] - 1;
                end
            end else begin
                if (m_pre[k] > 0) begin
                    m_pre[k]--;
                end else begin
                    m_oe[k] = 1'b0;
                    m_tac[k] = m_ta[k];
                    m_st[k] = 0;
                end
            end
        end
        m_pe[k] = p;
        m_ne[k] = n;
    endtask

    function automatic logic [4:0] m_vec(input int k);
        bit b;
        b = (m_st[k] != 0) || (m_tac[k] != 0);
        return {m_po[k], m_oe[k], b, m_pe[k], m_ne[k]};
    endfunction

    // One clock: drive at negedge, predict, then compare after posedge.
    task automatic cyc(input bit e, input bit r, input bit d);
        logic [4:0] x0, x1;
        @(negedge clk);
        ena = e;
        oe_req = r;
        din = d;
        for (int k = 0; k < 2; k++) model_step(k, e, r, d);
        q0.push_back(m_vec(0));
        q1.push_back(m_vec(1));
        @(posedge clk);
        #1;
        if (q0.size() == 0 || q1.size() == 0) begin
            chk({g_tag, "_qempty"}, 8'd1, 8'd0);
        end else begin
            x0 = q0.pop_front();
            x1 = q1.pop_front();
            chk({g_tag, "_u0"}, {3'b0, po0, oe0, bz0, pe0, ne0}, {3'b0, x0});
            chk({g_tag, "_u1"}, {3'b0, po1, oe1, bz1, pe1, ne1}, {3'b0, x1});
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_u0", {3'b0, po0, oe0, bz0, pe0, ne0}, 8'b0001_0000);
        chk("rst_u1", {3'b0, po1, oe1, bz1, pe1, ne1}, 8'b0001_0000);
        model_reset();
        q0.delete();
        q1.delete();
        @(negedge clk);
        ena = 1'b0;
        oe_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("por_u0", {3'b0, po0, oe0, bz0, pe0, ne0}, 8'b0001_0000);
        chk("por_u1", {3'b0, po1, oe1, bz1, pe1, ne1}, 8'b0001_0000);
        @(negedge clk);
        reset_n = 1'b1;

        g_tag = "s1";
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        async_reset();
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);

        g_tag = "s2";
        cyc(1, 1, 0);
        chk("s2_t0", {5'b0, po0, oe0, ne0}, 8'b0000_0011);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 1);

        g_tag = "s3";
        for (int i = 0; i < 3; i++) cyc(1, 1, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 1);

        g_tag = "s4";
        for (int i = 0; i < 40; i++) cyc(i % 4 == 0, i < 24, i >= 4);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0);

        g_tag = "s5";
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 1);
        chk("s5_rel_u1", {6'b0, po1, oe1}, 8'b0000_0000);
        chk("s6_pre_u0", {4'b0, po0, oe0, pe0, ne0}, 8'b0000_1110);
        cyc(1, 1, 1);
        chk("s5_redrive_u1", {5'b0, po1, oe1, pe1}, 8'b0000_0111);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0);

        g_tag = "rnd";
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 3) != 0, ($urandom % 4) != 0, $urandom % 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
